// File: rtl/instr_queue_decoder_if.sv
// Producer/consumer bundle for the instruction queue: enqueue handshake,
// dequeue handshake, decoded head fields and occupancy.
interface instr_queue_decoder_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [31:0]   in_instr;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   immediate;
    logic [25:0]   jump_address;
    logic [1:0]    instr_type;
    logic [LW-1:0] level;

    modport master (
        output in_instr, in_valid, out_ready,
        input  in_ready, out_valid, opcode, funct, rs, rt, rd,
               immediate, jump_address, instr_type, level
    );

    modport slave (
        input  in_instr, in_valid, out_ready,
        output in_ready, out_valid, opcode, funct, rs, rt, rd,
               immediate, jump_address, instr_type, level
    );
endinterface

// File: rtl/instr_queue_decoder.sv
// Circular-buffer instruction queue whose head word is decoded combinationally
// into MIPS-style fields and a format class (R / I / J / illegal).
module instr_queue_decoder #(
    parameter int DEPTH        = 4,
    parameter bit CLEAR_UNUSED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    instr_queue_decoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] count_reg, count_next;
    logic          push, pop;
    logic          in_ready_w, out_valid_w;

    assign in_ready_w  = (count_reg < LW'(DEPTH));
    assign out_valid_w = (count_reg != '0);
    assign push        = bus.in_valid & in_ready_w;
    assign pop         = out_valid_w & bus.out_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            // A word offered alongside flush is deliberately dropped.
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push)
                wr_ptr_next = (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_next = (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            if (push && !pop)
                count_next = count_reg + LW'(1);
            else if (pop && !push)
                count_next = count_reg - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is left unreset; reads are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr_reg] <= bus.in_instr;
    end

    logic [31:0] head;
    logic [1:0]  type_w;
    logic [5:0]  funct_w;
    logic [4:0]  rs_w, rt_w, rd_w;
    logic [15:0] imm_w;
    logic [25:0] ja_w;

    always_comb begin
        head = out_valid_w ? mem[rd_ptr_reg] : 32'h0;
        case (head[31:26])
            6'h00:                    type_w = 2'b00;
            6'h02, 6'h03:             type_w = 2'b10;
            6'h04, 6'h05, 6'h08, 6'h0A,
            6'h0C, 6'h0D, 6'h23, 6'h2B: type_w = 2'b01;
            default:                  type_w = 2'b11;
        endcase
        rs_w    = head[25:21];
        rt_w    = head[20:16];
        rd_w    = head[15:11];
        funct_w = head[5:0];
        imm_w   = head[15:0];
        ja_w    = head[25:0];
        if (CLEAR_UNUSED) begin
            case (type_w)
                2'b00: begin
                    imm_w = '0;
                    ja_w  = '0;
                end
                2'b01: begin
                    rd_w    = '0;
                    funct_w = '0;
                    ja_w    = '0;
                end
                2'b10: begin
                    rs_w    = '0;
                    rt_w    = '0;
                    rd_w    = '0;
                    funct_w = '0;
                    imm_w   = '0;
                end
                default: begin
                    rs_w    = '0;
                    rt_w    = '0;
                    rd_w    = '0;
                    funct_w = '0;
                    imm_w   = '0;
                    ja_w    = '0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = out_valid_w;
    assign bus.level        = count_reg;
    assign bus.opcode       = head[31:26];
    assign bus.instr_type   = type_w;
    assign bus.rs           = rs_w;
    assign bus.rt           = rt_w;
    assign bus.rd           = rd_w;
    assign bus.funct        = funct_w;
    assign bus.immediate    = imm_w;
    assign bus.jump_address = ja_w;
endmodule
